// File: rtl/system86_pkg.sv
// rtl/system86_pkg.sv - shared constants and types for the CUS42 tilemap address generator
package system86_pkg;

  localparam int RA_W   = 12;
  localparam int GA_W   = 15;
  localparam int CODE_W = 11;
  localparam int ATTR_W = 8;

  localparam int          REG_LAYER_BIT = 2;
  localparam logic [1:0]  REG_SX_LO     = 2'd0;
  localparam logic [1:0]  REG_SX_HI     = 2'd1;
  localparam logic [1:0]  REG_SY        = 2'd2;

  localparam int RD_ATTR_LSB      = 8;
  localparam int ATTR_CODE_HI_LSB = 0;
  localparam int ATTR_CODE_HI_W   = 3;

  typedef enum logic [1:0] {
    PH_A_ADDR = 2'd0,
    PH_A_DATA = 2'd1,
    PH_B_ADDR = 2'd2,
    PH_B_DATA = 2'd3
  } phase_e;

  // Shifter load lands on the slot phase offset by the fine scroll.
  function automatic phase_e strobe_phase(input logic [1:0] sx_lsb);
    return phase_e'(2'd3 + sx_lsb);
  endfunction

endpackage

// File: rtl/cus42_if.sv
// rtl/cus42_if.sv - timing, CPU, tilemap RAM and ROM signal bundle for CUS42
interface cus42_if;
  import system86_pkg::*;

  logic              HRESET;
  logic              VRESET;
  logic              FLIP;
  logic              CPU_WE;
  logic [2:0]        CPU_A;
  logic [7:0]        CPU_D;
  logic [15:0]       RD;
  logic [RA_W-1:0]   RA;
  logic [GA_W-1:0]   GA;
  logic [ATTR_W-1:0] MDO;
  logic              CLK_2H;
  logic              HA2;
  logic              HB2;

  modport master (
    output HRESET, VRESET, FLIP, CPU_WE, CPU_A, CPU_D, RD,
    input  RA, GA, MDO, CLK_2H, HA2, HB2
  );

  modport slave (
    input  HRESET, VRESET, FLIP, CPU_WE, CPU_A, CPU_D, RD,
    output RA, GA, MDO, CLK_2H, HA2, HB2
  );

endinterface

// File: rtl/cus42_layer.sv
// rtl/cus42_layer.sv - one scroll layer: pending/active scroll, x/y sum, code/attr capture
module cus42_layer
  import system86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hreset,
  input  logic              i_we,
  input  logic [1:0]        i_a,
  input  logic [7:0]        i_d,
  input  logic [8:0]        i_h,
  input  logic [7:0]        i_v,
  input  logic              i_flip,
  input  logic              i_cap,
  input  logic [15:0]       i_rd,
  output logic [RA_W-2:0]   o_tile,
  output logic [1:0]        o_sx_lsb,
  output logic [GA_W-1:0]   o_ga,
  output logic [ATTR_W-1:0] o_attr
);

  logic [8:0]        r_pend_sx, r_act_sx, w_pend_sx, w_x;
  logic [7:0]        r_pend_sy, r_act_sy, w_pend_sy, w_y;
  logic [CODE_W-1:0] r_code;
  logic [ATTR_W-1:0] r_attr;
  logic [2:0]        r_fine;
  logic              r_half;
  logic              w_unused;

  always_comb begin
    w_pend_sx = r_pend_sx;
    w_pend_sy = r_pend_sy;
    if (i_we) begin
      case (i_a)
        REG_SX_LO: w_pend_sx[7:0] = i_d;
        REG_SX_HI: w_pend_sx[8]   = i_d[0];
        REG_SY:    w_pend_sy      = i_d;
        default:   ;
      endcase
    end
  end

  assign w_x      = i_h + 9'd4 + r_act_sx;
  assign w_y      = i_v + r_act_sy;
  assign o_tile   = {w_y[7:3], w_x[8:3]};
  assign o_sx_lsb = r_act_sx[1:0];
  assign o_ga     = {r_code, r_fine, r_half};
  assign o_attr   = r_attr;
  assign w_unused = &{1'b0, w_x[1:0]};

  // Active copy takes the post-write pending value, so a write on the HRESET clock lands at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_sx <= '0;
      r_pend_sy <= '0;
      r_act_sx  <= '0;
      r_act_sy  <= '0;
      r_code    <= '0;
      r_attr    <= '0;
      r_fine    <= '0;
      r_half    <= 1'b0;
    end else begin
      r_pend_sx <= w_pend_sx;
      r_pend_sy <= w_pend_sy;
      if (i_hreset) begin
        r_act_sx <= w_pend_sx;
        r_act_sy <= w_pend_sy;
      end
      if (i_cap) begin
        r_code <= {i_rd[RD_ATTR_LSB+ATTR_CODE_HI_LSB +: ATTR_CODE_HI_W], i_rd[7:0]};
        r_attr <= i_rd[RD_ATTR_LSB +: ATTR_W];
        r_fine <= w_y[2:0] ^ {3{i_flip}};
        r_half <= w_x[2] ^ i_flip;
      end
    end
  end

endmodule

// File: rtl/cus42.sv
// rtl/cus42.sv - CUS42 two-layer tilemap address generator; FLIP_EN enables screen flip
module cus42
  import system86_pkg::*;
(
  input  logic   CLK_6M,
  input  logic   RST,
  cus42_if.slave bus
);

  logic [8:0]        r_hpos;
  logic [7:0]        r_vpos;
  logic [RA_W-1:0]   r_ra;
  logic              r_sel_b;
  logic              r_ha2;
  logic              r_hb2;
  phase_e            w_ph;
  logic [8:0]        w_h;
  logic [7:0]        w_v;
  logic              w_flip;
  logic              w_we_a, w_we_b, w_cap_a, w_cap_b;
  logic [RA_W-2:0]   w_tile_a, w_tile_b;
  logic [1:0]        w_sx_lsb_a, w_sx_lsb_b;
  logic [GA_W-1:0]   w_ga_a, w_ga_b;
  logic [ATTR_W-1:0] w_attr_a, w_attr_b;

`ifdef FLIP_EN
  assign w_flip = bus.FLIP;
  assign w_h    = w_flip ? ~r_hpos : r_hpos;
  assign w_v    = w_flip ? ~r_vpos : r_vpos;
`else
  logic w_unused;
  assign w_flip   = 1'b0;
  assign w_h      = r_hpos;
  assign w_v      = r_vpos;
  assign w_unused = bus.FLIP;
`endif

  assign w_ph    = phase_e'(r_hpos[1:0]);
  assign w_we_a  = bus.CPU_WE && !bus.CPU_A[REG_LAYER_BIT];
  assign w_we_b  = bus.CPU_WE &&  bus.CPU_A[REG_LAYER_BIT];
  assign w_cap_a = !bus.HRESET && (w_ph == PH_A_DATA);
  assign w_cap_b = !bus.HRESET && (w_ph == PH_B_DATA);

  cus42_layer u_layer_a (
    .clk      (CLK_6M),
    .rst      (RST),
    .i_hreset (bus.HRESET),
    .i_we     (w_we_a),
    .i_a      (bus.CPU_A[1:0]),
    .i_d      (bus.CPU_D),
    .i_h      (w_h),
    .i_v      (w_v),
    .i_flip   (w_flip),
    .i_cap    (w_cap_a),
    .i_rd     (bus.RD),
    .o_tile   (w_tile_a),
    .o_sx_lsb (w_sx_lsb_a),
    .o_ga     (w_ga_a),
    .o_attr   (w_attr_a)
  );

  cus42_layer u_layer_b (
    .clk      (CLK_6M),
    .rst      (RST),
    .i_hreset (bus.HRESET),
    .i_we     (w_we_b),
    .i_a      (bus.CPU_A[1:0]),
    .i_d      (bus.CPU_D),
    .i_h      (w_h),
    .i_v      (w_v),
    .i_flip   (w_flip),
    .i_cap    (w_cap_b),
    .i_rd     (bus.RD),
    .o_tile   (w_tile_b),
    .o_sx_lsb (w_sx_lsb_b),
    .o_ga     (w_ga_b),
    .o_attr   (w_attr_b)
  );

  // HRESET aborts the current slot: no address update and no strobe on that edge.
  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_ra    <= '0;
      r_sel_b <= 1'b0;
      r_ha2   <= 1'b0;
      r_hb2   <= 1'b0;
    end else if (bus.HRESET) begin
      r_hpos <= '0;
      r_vpos <= bus.VRESET ? 8'd0 : r_vpos + 8'd1;
      r_ha2  <= 1'b0;
      r_hb2  <= 1'b0;
    end else begin
      r_hpos <= r_hpos + 9'd1;
      r_ha2  <= (w_ph == strobe_phase(w_sx_lsb_a));
      r_hb2  <= (w_ph == strobe_phase(w_sx_lsb_b));
      case (w_ph)
        PH_A_ADDR: r_ra    <= {1'b0, w_tile_a};
        PH_A_DATA: r_sel_b <= 1'b0;
        PH_B_ADDR: r_ra    <= {1'b1, w_tile_b};
        PH_B_DATA: r_sel_b <= 1'b1;
      endcase
    end
  end

  assign bus.RA     = r_ra;
  assign bus.GA     = r_sel_b ? w_ga_b : w_ga_a;
  assign bus.MDO    = r_sel_b ? w_attr_b : w_attr_a;
  assign bus.CLK_2H = r_hpos[1];
  assign bus.HA2    = r_ha2;
  assign bus.HB2    = r_hb2;

endmodule
